// File: rtl/sprite_pixel_reader.sv
// Two-stage pixel reader for 32x32 palette-indexed sprites with transparency flag.
// Optional two-frame animation is enabled by defining SPRITE_ANIM_EN.
module sprite_pixel_reader #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int IDX_W       = 10,
  parameter int ANIM_PERIOD = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             flip_h,
  input  logic             pix_valid_in,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [IDX_W-1:0] sprite0 [0:SPRITE_H-1][0:SPRITE_W-1],
  input  logic [IDX_W-1:0] sprite1 [0:SPRITE_H-1][0:SPRITE_W-1],
  output logic [IDX_W-1:0] pal_idx,
  output logic             opaque,
  output logic             pix_valid_out,
  output logic             anim_sel
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam logic [XW-1:0] COL_MAX = XW'(SPRITE_W - 1);

  // Shadow copies of the sprite placement, only updated in vertical blank.
  logic [9:0] r_px;
  logic [9:0] r_py;
  logic       r_flip;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_px   <= '0;
      r_py   <= '0;
      r_flip <= 1'b0;
    end else if (frame_start) begin
      r_px   <= pos_x;
      r_py   <= pos_y;
      r_flip <= flip_h;
    end
  end

`ifdef SPRITE_ANIM_EN
  localparam int CW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ANIM_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_anim_sel;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt      <= '0;
      r_anim_sel <= 1'b0;
    end else if (frame_start) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt      <= '0;
        r_anim_sel <= ~r_anim_sel;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign anim_sel = r_anim_sel;
`else
  // Without animation the second frame is never looked at.
  logic w_unused_sprite1;

  always_comb begin
    w_unused_sprite1 = (ANIM_PERIOD == 0);
    for (int r = 0; r < SPRITE_H; r++) begin
      for (int c = 0; c < SPRITE_W; c++) begin
        w_unused_sprite1 = w_unused_sprite1 | (|sprite1[r][c]);
      end
    end
  end

  assign anim_sel = 1'b0;
`endif

  // Stage 1: offset from the latched top-left corner. A negative offset
  // wraps to a large unsigned value, so one compare covers both bounds.
  logic [10:0] w_rel_x;
  logic [10:0] w_rel_y;
  logic        w_inbox;

  assign w_rel_x = {1'b0, DrawX} - {1'b0, r_px};
  assign w_rel_y = {1'b0, DrawY} - {1'b0, r_py};
  assign w_inbox = (w_rel_x < 11'(SPRITE_W)) && (w_rel_y < 11'(SPRITE_H));

  logic [XW-1:0] r_s1_rx;
  logic [YW-1:0] r_s1_ry;
  logic          r_s1_inbox;
  logic          r_s1_valid;
`ifdef SPRITE_ANIM_EN
  logic          r_s1_anim;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_rx    <= '0;
      r_s1_ry    <= '0;
      r_s1_inbox <= 1'b0;
      r_s1_valid <= 1'b0;
`ifdef SPRITE_ANIM_EN
      r_s1_anim  <= 1'b0;
`endif
    end else begin
      r_s1_rx    <= w_rel_x[XW-1:0];
      r_s1_ry    <= w_rel_y[YW-1:0];
      r_s1_inbox <= w_inbox;
      r_s1_valid <= pix_valid_in;
`ifdef SPRITE_ANIM_EN
      r_s1_anim  <= r_anim_sel;
`endif
    end
  end

  // Stage 2: mirrored column select and ROM lookup.
  logic [XW-1:0]    w_col;
  logic [IDX_W-1:0] w_idx;
  logic             w_opaque;

  always_comb begin
    w_col = r_flip ? (COL_MAX - r_s1_rx) : r_s1_rx;
`ifdef SPRITE_ANIM_EN
    w_idx = r_s1_anim ? sprite1[r_s1_ry][w_col] : sprite0[r_s1_ry][w_col];
`else
    w_idx = sprite0[r_s1_ry][w_col];
`endif
    w_opaque = r_s1_inbox & r_s1_valid & (w_idx != '0);
  end

  logic [IDX_W-1:0] r_pal_idx;
  logic             r_opaque;
  logic             r_valid_out;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pal_idx   <= '0;
      r_opaque    <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_pal_idx   <= w_opaque ? w_idx : '0;
      r_opaque    <= w_opaque;
      r_valid_out <= r_s1_valid;
    end
  end

  assign pal_idx       = r_pal_idx;
  assign opaque        = r_opaque;
  assign pix_valid_out = r_valid_out;

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Bench for sprite_pixel_reader: directed table, hand sequences and random stream
// checked against a coordinate-arithmetic model of the sprite lookup.
module tb_sprite_pixel_reader;
  localparam int SW = 32;
  localparam int SH = 32;
  localparam int IW = 10;
  localparam int AP = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_start;
  logic [9:0]    pos_x, pos_y, DrawX, DrawY;
  logic          flip_h, pix_valid_in;
  logic [IW-1:0] sprite0 [0:SH-1][0:SW-1];
  logic [IW-1:0] sprite1 [0:SH-1][0:SW-1];
  logic [IW-1:0] pal_idx;
  logic          opaque, pix_valid_out, anim_sel;

  sprite_pixel_reader #(.SPRITE_W(SW), .SPRITE_H(SH), .IDX_W(IW), .ANIM_PERIOD(AP)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
    .sprite0(sprite0), .sprite1(sprite1),
    .pal_idx(pal_idx), .opaque(opaque), .pix_valid_out(pix_valid_out), .anim_sel(anim_sel)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the sprite placement should be, and how many
  // frame_start pulses have been seen since reset.
  int m_px = 0, m_py = 0, m_pulses = 0;
  bit m_flip = 1'b0;

  // Expected {pix_valid_out, opaque, pal_idx}, oldest first.
  logic [IW+1:0] exp_q[$];

  typedef struct {
    bit    fs;
    int    px, py;
    bit    fl;
    int    dx, dy;
    bit    v;
    int    e_idx;
    bit    e_op;
    bit    e_v;
    string name;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_sel();
`ifdef SPRITE_ANIM_EN
    return ((m_pulses / AP) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [IW+1:0] model_pix(input logic [9:0] dx, input logic [9:0] dy, input bit v);
    int rx, ry, col;
    logic [IW-1:0] e;
    bit op;
    rx = int'(dx) - m_px;
    ry = int'(dy) - m_py;
    e  = '0;
    op = 1'b0;
    if (v && rx >= 0 && rx < SW && ry >= 0 && ry < SH) begin
      col = m_flip ? (SW - 1 - rx) : rx;
      e   = model_sel() ? sprite1[ry][col] : sprite0[ry][col];
      op  = (e != 0);
    end
    if (!op) e = '0;
    return {v, op, e};
  endfunction

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input bit fs, input int px, input int py, input bit fl,
                      input int dx, input int dy, input bit v);
    logic [IW+1:0] e;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("pipe_valid", 32'(pix_valid_out), 32'(e[IW+1]));
      check("pipe_opaque", 32'(opaque), 32'(e[IW]));
      check("pipe_idx", 32'(pal_idx), 32'(e[IW-1:0]));
    end
    check("anim_sel", 32'(anim_sel), 32'(model_sel()));
    frame_start  = fs;
    pos_x        = 10'(px);
    pos_y        = 10'(py);
    flip_h       = fl;
    DrawX        = 10'(dx);
    DrawY        = 10'(dy);
    pix_valid_in = v;
    exp_q.push_back(model_pix(10'(dx), 10'(dy), v));
    if (fs) begin
      m_px = px; m_py = py; m_flip = fl; m_pulses++;
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    step(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
         $urandom_range(0, 1023), $urandom_range(0, 1023), 0);
  endtask

  task automatic pixel(input int dx, input int dy);
    step(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)), dx, dy, 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_px = 0; m_py = 0; m_flip = 0; m_pulses = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_pal_idx"}, 32'(pal_idx), 0);
    check({name, "_opaque"}, 32'(opaque), 0);
    check({name, "_valid"}, 32'(pix_valid_out), 0);
    check({name, "_anim_sel"}, 32'(anim_sel), 0);
  endtask

  task automatic add_vec(input bit fs, input int px, input int py, input bit fl, input int dx,
                         input int dy, input bit v, input int ei, input bit eo, input bit ev,
                         input string name);
    vec_t t;
    t.fs = fs; t.px = px; t.py = py; t.fl = fl; t.dx = dx; t.dy = dy; t.v = v;
    t.e_idx = ei; t.e_op = eo; t.e_v = ev; t.name = name;
    tbl.push_back(t);
  endtask

  initial begin
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        sprite0[r][c] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, 1023));
        sprite1[r][c] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, 1023));
      end
    end
    sprite0[3][5]   = 10'd267;
    sprite0[3][26]  = 10'd58;
    sprite0[4][6]   = 10'd0;
    sprite0[3][31]  = 10'd5;
    sprite0[31][31] = 10'd999;
    sprite1[3][5]   = 10'd777;

    add_vec(1, 100, 50, 0, 105, 53, 1, 267, 1, 1, "basic");
    add_vec(0, 0,   0,  0, 105, 53, 0, 0,   0, 0, "valid_low");
    add_vec(1, 100, 50, 1, 105, 53, 1, 58,  1, 1, "flip");
    add_vec(1, 100, 50, 0, 106, 54, 1, 0,   0, 1, "transparent");
    add_vec(0, 0,   0,  0, 99,  53, 1, 0,   0, 1, "left_clip");
    add_vec(1, 630, 50, 0, 2,   53, 1, 0,   0, 1, "no_wrap");
    add_vec(0, 0,   0,  0, 661, 53, 1, 5,   1, 1, "right_col");
    add_vec(1, 0,   0,  0, 32,  0,  1, 0,   0, 1, "col_32_out");
    add_vec(0, 0,   0,  0, 31,  31, 1, 999, 1, 1, "corner");
    add_vec(0, 0,   0,  0, 31,  32, 1, 0,   0, 1, "row_32_out");

    Reset = 1; frame_start = 0; pos_x = 0; pos_y = 0; flip_h = 0;
    pix_valid_in = 0; DrawX = 0; DrawY = 0;
    repeat (2) @(negedge Clk);
    Reset = 0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      check_outputs_zero("reset_idle");
      @(negedge Clk);
    end

    foreach (tbl[i]) begin
      if (tbl[i].fs) step(1, tbl[i].px, tbl[i].py, tbl[i].fl, 0, 0, 0);
      step(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, tbl[i].dx, tbl[i].dy, tbl[i].v);
      idle();
      check({tbl[i].name, "_idx"}, 32'(pal_idx), 32'(tbl[i].e_idx));
      check({tbl[i].name, "_opaque"}, 32'(opaque), 32'(tbl[i].e_op));
      check({tbl[i].name, "_valid"}, 32'(pix_valid_out), 32'(tbl[i].e_v));
    end

    // Mid-frame move: new position without frame_start is not seen.
    step(1, 100, 50, 0, 0, 0, 0);
    step(0, 200, 10, 1, 105, 53, 1);
    idle();
    check("midframe_idx", 32'(pal_idx), 267);
    check("midframe_opaque", 32'(opaque), 1);

    // Animation: toggle after the 8th pulse, back after the 16th.
    Reset = 1; @(negedge Clk); Reset = 0; model_reset();
    for (int p = 1; p <= 16; p++) begin
      step(1, 100, 50, 0, 0, 0, 0);
      idle();
      if (p == 7) check("anim_after7", 32'(anim_sel), 0);
      if (p == 8) begin
`ifdef SPRITE_ANIM_EN
        check("anim_after8", 32'(anim_sel), 1);
`else
        check("anim_after8", 32'(anim_sel), 0);
`endif
        pixel(105, 53);
        idle();
`ifdef SPRITE_ANIM_EN
        check("anim_frame1_idx", 32'(pal_idx), 777);
`else
        check("anim_frame1_idx", 32'(pal_idx), 267);
`endif
      end
      if (p == 16) check("anim_after16", 32'(anim_sel), 0);
    end

    // Reset in the middle of an active line.
    step(1, 100, 50, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) step(1, 100, 50, 1, 0, 0, 0);
    pixel(105, 53);
    pixel(106, 53);
    Reset = 1; pix_valid_in = 1; DrawX = 10'd105; DrawY = 10'd53;
    @(negedge Clk);
    check_outputs_zero("reset_midline");
    Reset = 0;
    model_reset();
    pixel(5, 3);
    idle();
    check("post_reset_px0_idx", 32'(pal_idx), 267);
    check("post_reset_px0_opaque", 32'(opaque), 1);

    // Random stream, including mid-frame position noise and blanking pulses.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(1, $urandom_range(0, 700), $urandom_range(0, 500), 1'($urandom_range(0, 1)), 0, 0, 0);
      end else begin
        step(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
             m_px + $urandom_range(0, 40) - 4, m_py + $urandom_range(0, 40) - 4,
             $urandom_range(0, 4) != 0);
      end
    end
    idle();
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_reader.md
# sprite_pixel_reader

Pipelined per-pixel reader for 32x32 palette-indexed sprite frames. It consumes the VGA scan coordinates and a sprite's screen position, then fetches the matching palette index from one of two animation frames. It flags transparent pixels (index 0) so the colour mapper can composite the sprite over the background. It sits between the sprite ROM modules and the palette/colour-mapper stage.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- IDX_W, 10, palette index width
- ANIM_PERIOD, 8, frames per animation step (≥1)

Ports:
- Clk  in  1  pixel clock, single clock domain
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_x  in  10  sprite top-left X; sampled only on frame_start
- pos_y  in  10  sprite top-left Y; sampled only on frame_start
- flip_h  in  1  horizontal mirror; sampled only on frame_start
- pix_valid_in  in  1  DrawX/DrawY carry an active pixel this cycle
- DrawX  in  10  current scan X
- DrawY  in  10  current scan Y
- sprite0  in  IDX_W x [0:SPRITE_H-1][0:SPRITE_W-1]  frame 0 indices, [row][col]
- sprite1  in  IDX_W x [0:SPRITE_H-1][0:SPRITE_W-1]  frame 1 indices
- pal_idx  out  IDX_W  palette index; 0 when not opaque
- opaque  out  1  pixel inside sprite box and index ≠ 0
- pix_valid_out  out  1  pix_valid_in delayed by 2 cycles
- anim_sel  out  1  currently displayed frame (0 or 1)

## Operation
- Shadow registers px_l, py_l, flip_l load from pos_x, pos_y, flip_h on frame_start. Position changes mid-frame are never visible (no tearing).
- Animation counter cnt, range 0..ANIM_PERIOD-1, advances on frame_start. At ANIM_PERIOD-1 it wraps to 0 and toggles anim_sel. The anim_sel change takes effect for pixels entering stage 1 after the pulse edge.
- Stage 1 (registered):
  - rel_x = {1'b0,DrawX} − {1'b0,px_l}, 11-bit two's complement; rel_y likewise.
  - inbox = rel_x, rel_y both non-negative and < SPRITE_W / SPRITE_H.
  - Register rel_x[4:0], rel_y[4:0], inbox, pix_valid_in, anim_sel.
  - Sprites partially off the right/bottom edge clip naturally. No wrap-around to column 0.
- Stage 2 (registered):
  - col = flip_l ? SPRITE_W−1−rel_x : rel_x.
  - idx = selected frame [rel_y][col].
  - opaque = inbox & pix_valid & (idx ≠ 0).
  - pal_idx = opaque ? idx : 0.
- When pix_valid_in is low, stage registers still shift. The outputs show pix_valid_out=0, opaque=0, pal_idx=0.

## Timing
- Latency: DrawX/DrawY at edge N produce outputs after edge N+2. Throughput is one pixel per clock, with no stalls.
- frame_start coincident with pix_valid_in: that pixel uses the pre-update px_l/py_l/flip_l/anim_sel. The new values apply from the next cycle.
- flip_l is read in stage 2. Any pixel whose stage 2 falls in the cycle after frame_start uses the new flip_l; the design tolerates this because frame_start only occurs in blanking.
- Reset (any cycle, including mid-line) clears on the next edge:
  - outputs: pal_idx=0, opaque=0, pix_valid_out=0, anim_sel=0
  - state: cnt=0, px_l=py_l=0, flip_l=0, all pipeline registers 0
- Reset dominates frame_start in the same cycle.

## Configuration
- SPRITE_ANIM_EN defined: counter and toggle behave as described; sprite1 is selected when anim_sel=1.
- SPRITE_ANIM_EN undefined:
  - cnt is removed; anim_sel is held at 0.
  - sprite1 is ignored, and only sprite0 is read.
  - Latency is unchanged.

## Test plan
- Reset then idle: pal_idx=0, opaque=0, pix_valid_out=0, anim_sel=0 for 10 cycles.
- Basic lookup: frame_start with pos=(100,50); bench sets sprite0[3][5]=10'd267. Drive DrawX=105, DrawY=53, valid → two cycles later pal_idx=267, opaque=1, pix_valid_out=1.
- Flip: same stimulus with flip_h=1 latched. Bench sets sprite0[3][26]=10'd58 → pal_idx=58, opaque=1.
- Transparency/clip:
  - Index 0 inside box → opaque=0, pal_idx=0.
  - DrawX=99 (rel_x=−1) → opaque=0.
  - pos_x=630, DrawX=2 → opaque=0 (no wrap).
- Animation (SPRITE_ANIM_EN, ANIM_PERIOD=8): 8 frame_start pulses → anim_sel toggles to 1 exactly after the 8th. The next in-box pixel reads sprite1; the 16th pulse returns anim_sel to 0.
- Mid-frame move plus reset: change pos_x without frame_start → lookup still uses the old position. Assert Reset during an active line → outputs are 0 one edge later; px_l=0, and anim_sel/cnt are cleared.
